// File: rtl/alt_xcvr_rcfg_strm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alt_xcvr_rcfg_strm_pkg
// Purpose  : Shared types and constants for the reconfiguration streamer.
//            It holds the per-IP streamer parameter set (config ROM image,
//            depth and word width), the ROM entry layout, the end marker,
//            the FSM state type and an entry decode helper.
// Ports    : none (package)
// Options  : RCFG_STRM_VERIFY_EN adds the VERIFY state to the state type.
// Revision : 1.0 - initial release
// ============================================================================
package alt_xcvr_rcfg_strm_pkg;

  // Streamer parameter set: all profiles concatenated, each ended by a marker.
  localparam int CFG_ROM_DATA_W = 26;
  localparam int CFG_ROM_DEPTH  = 4;

  // Entry layout: {addr[25:16], mask[15:8], data[7:0]}
  localparam int ADDR_MSB = 25;
  localparam int ADDR_LSB = 16;
  localparam int MASK_MSB = 15;
  localparam int MASK_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [CFG_ROM_DATA_W-1:0] END_MARKER = 26'h3FFFFFF;

  // Profile 0: entry 0 + marker; profile 1: entry 2 + marker.
  // Both touch bits [3:0] of register 0x108.
  localparam logic [CFG_ROM_DEPTH-1:0][CFG_ROM_DATA_W-1:0] CONFIG_ROM = {
    END_MARKER,      // [3]
    26'h1080F03,     // [2] addr 0x108, mask 0x0F, data 0x03
    END_MARKER,      // [1]
    26'h1080F04      // [0] addr 0x108, mask 0x0F, data 0x04
  };

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEEK,
    ST_SEEK_WAIT,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_AV_RD,
    ST_AV_WR,
`ifdef RCFG_STRM_VERIFY_EN
    ST_VERIFY,
`endif
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic [ADDR_MSB-ADDR_LSB:0] addr;
    logic [MASK_MSB-MASK_LSB:0] mask;
    logic [DATA_MSB-DATA_LSB:0] data;
  } rom_entry_t;

  function automatic rom_entry_t decode_entry(input logic [CFG_ROM_DATA_W-1:0] raw);
    rom_entry_t e;
    e.addr = raw[ADDR_MSB:ADDR_LSB];
    e.mask = raw[MASK_MSB:MASK_LSB];
    e.data = raw[DATA_MSB:DATA_LSB];
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alt_xcvr_rcfg_strm_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : alt_xcvr_rcfg_strm_engine_if
// Purpose  : Avalon-MM reconfiguration bus between the streamer (master)
//            and the PHY/ATX PLL reconfig slave.
// Signals  : avmm_address (ADDR_W), avmm_read, avmm_write,
//            avmm_writedata (8)      - master -> slave
//            avmm_readdata (8), avmm_waitrequest - slave -> master
// Revision : 1.0 - initial release
// ============================================================================
interface alt_xcvr_rcfg_strm_engine_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] avmm_address;
  logic              avmm_read;
  logic              avmm_write;
  logic [7:0]        avmm_writedata;
  logic [7:0]        avmm_readdata;
  logic              avmm_waitrequest;

  modport master (
    output avmm_address, avmm_read, avmm_write, avmm_writedata,
    input  avmm_readdata, avmm_waitrequest
  );

  modport slave (
    input  avmm_address, avmm_read, avmm_write, avmm_writedata,
    output avmm_readdata, avmm_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/alt_xcvr_rcfg_strm_rom.sv
`default_nettype none
// ============================================================================
// Module   : alt_xcvr_rcfg_strm_rom
// Purpose  : Registered-output ROM holding the streamer config image.
//            Data for addr_i appears on rdata_o one clock later. Addresses
//            at or beyond DEPTH read back as the end marker.
// Ports    : clk     in  clock
//            addr_i  in  PTR_W  entry pointer
//            rdata_o out 26     registered entry
// Revision : 1.0 - initial release
// ============================================================================
module alt_xcvr_rcfg_strm_rom
  import alt_xcvr_rcfg_strm_pkg::*;
#(
  parameter int DEPTH = CFG_ROM_DEPTH,
  parameter int PTR_W = $clog2(DEPTH + 1),
  parameter logic [DEPTH-1:0][CFG_ROM_DATA_W-1:0] INIT = CONFIG_ROM
) (
  input  wire                       clk,
  input  wire  [PTR_W-1:0]          addr_i,
  output logic [CFG_ROM_DATA_W-1:0] rdata_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] C_LIMIT = PTR_W'(DEPTH);

  logic [CFG_ROM_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (addr_i < C_LIMIT) begin
      rdata_q <= INIT[addr_i[AW-1:0]];
    end else begin
      rdata_q <= END_MARKER;
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/alt_xcvr_rcfg_strm_engine.sv
`default_nettype none
// ============================================================================
// Module   : alt_xcvr_rcfg_strm_engine
// Purpose  : Walks one end-marker-terminated profile of the streamer ROM
//            and applies each {addr, mask, data} entry to the reconfig slave
//            as a read-modify-write over Avalon-MM.
// Ports    : clk          in  reconfiguration clock
//            reset_n      in  asynchronous active-low reset
//            start        in  one-cycle request, ignored while busy
//            profile_sel  in  PROF_W profile index, sampled on start
//            busy         out high from the cycle after start until done
//            done         out one-cycle completion pulse
//            error        out sticky until next accepted start
//            avmm         master modport of alt_xcvr_rcfg_strm_engine_if
// Options  : RCFG_STRM_VERIFY_EN - read back each written register and
//            abort the profile with error on a masked mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module alt_xcvr_rcfg_strm_engine
  import alt_xcvr_rcfg_strm_pkg::*;
#(
  parameter int ROM_DEPTH    = CFG_ROM_DEPTH,
  parameter int NUM_PROFILES = 2,
  parameter int PROF_W       = 1,
  parameter int ADDR_W       = 10,
  parameter logic [ROM_DEPTH-1:0][CFG_ROM_DATA_W-1:0] ROM_INIT = CONFIG_ROM
) (
  input  wire                clk,
  input  wire                reset_n,
  input  wire                start,
  input  wire  [PROF_W-1:0]  profile_sel,
  output logic               busy,
  output logic               done,
  output logic               error,
  alt_xcvr_rcfg_strm_engine_if.master avmm
);
  localparam int PTR_W = $clog2(ROM_DEPTH + 1);
  localparam int PW1   = PROF_W + 1;
  localparam logic [PTR_W-1:0] C_PTR_END  = PTR_W'(ROM_DEPTH);
  localparam logic [PW1-1:0]   C_NUM_PROF = PW1'(NUM_PROFILES);

  state_t            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PW1-1:0]    mcnt_q;     // end markers passed while seeking
  logic [PW1-1:0]    sel_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        mask_q;
  logic [7:0]        data_q;
  logic [7:0]        wdata_q;

  logic [CFG_ROM_DATA_W-1:0] rom_rdata;
  rom_entry_t                entry_d;
  logic                      is_marker_d;
  logic [PW1-1:0]            mcnt_inc_d;
  logic [7:0]                merged_d;

  alt_xcvr_rcfg_strm_rom #(
    .DEPTH (ROM_DEPTH),
    .PTR_W (PTR_W),
    .INIT  (ROM_INIT)
  ) u_rom (
    .clk     (clk),
    .addr_i  (ptr_q),
    .rdata_o (rom_rdata)
  );

  assign entry_d     = decode_entry(rom_rdata);
  assign is_marker_d = (rom_rdata == END_MARKER);
  assign mcnt_inc_d  = mcnt_q + 1'b1;
  assign merged_d    = (avmm.avmm_readdata & ~mask_q) | (data_q & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      mcnt_q  <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if ({1'b0, profile_sel} < C_NUM_PROF) begin
              error_q <= 1'b0;
              busy_q  <= 1'b1;
              ptr_q   <= '0;
              mcnt_q  <= '0;
              sel_q   <= {1'b0, profile_sel};
              // Profile 0 starts at entry 0, nothing to skip.
              state_q <= (profile_sel == '0) ? ST_FETCH : ST_SEEK;
            end else begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end

        ST_SEEK: begin
          if (ptr_q == C_PTR_END) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            state_q <= ST_SEEK_WAIT;
          end
        end

        ST_SEEK_WAIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (is_marker_d) begin
            mcnt_q  <= mcnt_inc_d;
            // Pointer now addresses the first entry of the wanted profile.
            state_q <= (mcnt_inc_d == sel_q) ? ST_FETCH : ST_SEEK;
          end else begin
            state_q <= ST_SEEK;
          end
        end

        ST_FETCH: begin
          if (ptr_q == C_PTR_END) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            state_q <= ST_FETCH_WAIT;
          end
        end

        ST_FETCH_WAIT: begin
          if (is_marker_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            addr_q  <= ADDR_W'(entry_d.addr);
            mask_q  <= entry_d.mask;
            data_q  <= entry_d.data;
            rd_q    <= 1'b1;
            state_q <= ST_AV_RD;
          end
        end

        ST_AV_RD: begin
          if (!avmm.avmm_waitrequest) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b1;
            wdata_q <= merged_d;
            state_q <= ST_AV_WR;
          end
        end

        ST_AV_WR: begin
          if (!avmm.avmm_waitrequest) begin
            wr_q  <= 1'b0;
            ptr_q <= ptr_q + 1'b1;
`ifdef RCFG_STRM_VERIFY_EN
            rd_q    <= 1'b1;
            state_q <= ST_VERIFY;
`else
            state_q <= ST_FETCH;
`endif
          end
        end

`ifdef RCFG_STRM_VERIFY_EN
        ST_VERIFY: begin
          if (!avmm.avmm_waitrequest) begin
            rd_q <= 1'b0;
            if ((avmm.avmm_readdata & mask_q) != (data_q & mask_q)) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
`endif

        ST_FINISH: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

  assign avmm.avmm_address   = addr_q;
  assign avmm.avmm_read      = rd_q;
  assign avmm.avmm_write     = wr_q;
  assign avmm.avmm_writedata = wdata_q;

endmodule
`default_nettype wire

// File: doc/alt_xcvr_rcfg_strm_engine.md
Name: alt_xcvr_rcfg_strm_engine

Overview:
Consumer of the per-IP streamer parameter package (config_rom, rom_depth, rom_data_width). On start, it walks the selected profile's ROM entries. Each entry is {addr[25:16], mask[15:8], data[7:0]}, and the profile ends at 26'h3FFFFFF. For each entry it does a read-modify-write over the transceiver/ATX PLL Avalon-MM reconfiguration port. It sits between the reconfiguration controller (profile request) and the PHY/PLL reconfig slave.

Parameters:
ROM_DEPTH, 4, number of 26-bit ROM entries (all profiles concatenated).
NUM_PROFILES, 2, number of end-marker-terminated profiles.
PROF_W, 1, width of profile_sel, equal to clog2(NUM_PROFILES) with a minimum of 1.
ADDR_W, 10, Avalon-MM address width.

Ports:
clk  in  1  reconfiguration clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; ignored while busy
profile_sel  in  PROF_W  profile index, sampled on start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse on completion (success or error)
error  out  1  sticky until next accepted start
avmm_address  out  ADDR_W  reconfig address
avmm_read  out  1  read strobe, held until accepted
avmm_write  out  1  write strobe, held until accepted
avmm_writedata  out  8  merged write data
avmm_readdata  in  8  valid in the cycle avmm_read is high and avmm_waitrequest is low
avmm_waitrequest  in  1  slave stall

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, ROM pointer 0.
- ROM sub-module is synchronous: rom_rdata is valid 1 cycle after rom_addr.
- FSM states: IDLE, SEEK, SEEK_WAIT, FETCH, FETCH_WAIT, AV_RD, AV_WR, (VERIFY), FINISH.
- IDLE:
  - start with profile_sel < NUM_PROFILES: clear error, set busy, pointer = 0, marker count = 0, go to SEEK. If profile_sel == 0, go directly to FETCH.
  - start with profile_sel >= NUM_PROFILES: set error, go to FINISH.
- SEEK/SEEK_WAIT: read entries sequentially. Each end marker increments the marker count. When the count equals profile_sel, the pointer is the next entry; go to FETCH.
- FETCH/FETCH_WAIT:
  - End marker: go to FINISH with no error.
  - Otherwise: latch addr/mask/data, go to AV_RD.
- Pointer exhaustion: if the pointer reaches ROM_DEPTH without finding the needed marker (in SEEK or FETCH), set error and go to FINISH.
- AV_RD: avmm_read = 1 and avmm_address = addr, held while avmm_waitrequest = 1. On accept, capture merged = (readdata & ~mask) | (data & mask), then go to AV_WR.
- AV_WR: avmm_write = 1 with avmm_writedata = merged, held while waitrequest = 1. On accept, increment the pointer and go to FETCH (or VERIFY when the feature is enabled).
- Write is always issued, even when merged == readdata.
- Read and write are never asserted in the same cycle. Address and data are stable while stalled.
- FINISH: done = 1 for one cycle, busy = 0, return to IDLE.
- Latency per entry (no stalls): 2 cycles fetch + 1 cycle read + 1 cycle write.
- start while busy: ignored. start in the FINISH cycle: ignored.
- Reset mid-operation: a strobe in flight drops immediately. No partial write is retried after reset.
- No timeout: an indefinitely stalled waitrequest holds the FSM.

Optional Feature:
RCFG_STRM_VERIFY_EN
- Defined: after each accepted write, VERIFY issues a read of the same address. If (readdata & mask) != (data & mask), error is set, the remaining entries are skipped, and the FSM goes to FINISH.
- Undefined: VERIFY state and its logic are absent; AV_WR goes straight to FETCH.

Decomposition:
- Shared package alt_xcvr_rcfg_strm_pkg holds:
  - state enum typedef
  - entry field positions (ADDR_MSB/LSB, MASK_MSB/LSB, DATA_MSB/LSB)
  - END_MARKER = 26'h3FFFFFF
  - entry struct typedef {addr, mask, data}
- One sub-module, alt_xcvr_rcfg_strm_rom: registered-output ROM indexed from the parameter package's config_rom.

Test Plan:
- Profile 0, slave returns 0xF3 for addr 0x108 -> read 0x108, write 0xF4 to 0x108, done pulse, error = 0, exactly 1 write.
- Profile 1, readdata 0xF3 -> SEEK skips 2 entries, write 0xF3 to 0x108 (write still issued), done, error = 0.
- Profile 0 with waitrequest held 5 cycles on the read and 3 cycles on the write -> strobes, address, and writedata stable throughout; single accept each.
- profile_sel = 2 with NUM_PROFILES = 3 and only 2 markers in the ROM -> error = 1, done pulse, no Avalon traffic. profile_sel = 3 -> immediate error, done.
- reset_n deasserted during AV_WR stall -> all outputs 0 next edge; a new start afterwards completes normally.
- RCFG_STRM_VERIFY_EN, readback 0xF0 after the write of 0xF4 -> error = 1, done pulse. Readback 0xF4 -> error = 0.
